// File: rtl/uart_pkg.sv
// Shared types for the UART frame parser: parser states, error causes and
// the default frame start marker.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } frame_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CHKSUM  = 2'b01,
        ERR_LEN     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } frame_err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_payload_buf.sv
// Payload register file: synchronous write, combinational read.
// Contents are never reset; stale entries past the frame length are
// simply left behind for the next frame to overwrite.
module frame_payload_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write one payload byte per strobe
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser downstream of the UART receiver. Delimits
// SYNC, CMD, LEN, payload[LEN], CHK frames, verifies the XOR checksum and
// holds each good frame for the loader behind a valid/ready handshake.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    MAX_LEN        = 16,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int                    TIMEOUT_CYCLES = 100000,
    parameter int                    AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [DATA_WIDTH-1:0] frame_cmd,
    output logic [DATA_WIDTH-1:0] frame_len,
    input  logic [AW-1:0]         buf_addr,
    output logic [DATA_WIDTH-1:0] buf_data,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]         TMAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] LENMAX = DATA_WIDTH'(MAX_LEN);

    frame_state_t          r_state,    w_state;
    logic [DATA_WIDTH-1:0] r_cmd,      w_cmd;
    logic [DATA_WIDTH-1:0] r_len,      w_len;
    logic [DATA_WIDTH-1:0] r_chk,      w_chk;
    logic [AW-1:0]         r_idx,      w_idx;
    logic [TW-1:0]         r_tcnt,     w_tcnt;
    logic                  r_err,      w_err;
    frame_err_t            r_err_code, w_err_code;
    logic                  r_overrun,  w_overrun;
    logic                  w_we;
    logic                  w_last;

    // The index is compared in byte width so LEN-1 lines up with it
    assign w_last = (DATA_WIDTH'(r_idx) == (r_len - DATA_WIDTH'(1)));

    // State and datapath registers; reset drops a held frame immediately
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= ST_HUNT;
            r_cmd      <= '0;
            r_len      <= '0;
            r_chk      <= '0;
            r_idx      <= '0;
            r_tcnt     <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cmd      <= w_cmd;
            r_len      <= w_len;
            r_chk      <= w_chk;
            r_idx      <= w_idx;
            r_tcnt     <= w_tcnt;
            r_err      <= w_err;
            r_err_code <= w_err_code;
            r_overrun  <= w_overrun;
        end
    end

    // Next-state, checksum, index, timeout and pulse generation
    always_comb begin
        w_state    = r_state;
        w_cmd      = r_cmd;
        w_len      = r_len;
        w_chk      = r_chk;
        w_idx      = r_idx;
        w_tcnt     = r_tcnt;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        w_overrun  = 1'b0;
        w_we       = 1'b0;

        case (r_state)
            ST_HUNT: begin
                w_tcnt = '0;
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    w_state = ST_CMD;
                end
            end

            ST_HOLD: begin
                w_tcnt = '0;
                if (rx_done) begin
                    w_overrun = 1'b1;
                end
                if (frame_ready) begin
                    w_state = ST_HUNT;
                end
            end

            ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK: begin
                if (rx_done) begin
                    w_tcnt = '0;
                    case (r_state)
                        ST_CMD: begin
                            w_cmd   = rx_data;
                            w_chk   = rx_data;
                            w_state = ST_LEN;
                        end
                        ST_LEN: begin
                            if (rx_data > LENMAX) begin
                                w_err      = 1'b1;
                                w_err_code = ERR_LEN;
                                w_state    = ST_HUNT;
                            end else begin
                                w_len   = rx_data;
                                w_chk   = r_chk ^ rx_data;
                                w_idx   = '0;
                                w_state = (rx_data == '0) ? ST_CHECK : ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            w_we  = 1'b1;
                            w_chk = r_chk ^ rx_data;
                            w_idx = r_idx + AW'(1);
                            if (w_last) begin
                                w_state = ST_CHECK;
                            end
                        end
                        default: begin
                            if (rx_data == r_chk) begin
                                w_state = ST_HOLD;
                            end else begin
                                w_err      = 1'b1;
                                w_err_code = ERR_CHKSUM;
                                w_state    = ST_HUNT;
                            end
                        end
                    endcase
                end else if (r_tcnt == TMAX) begin
                    w_tcnt     = '0;
                    w_err      = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                    w_state    = ST_HUNT;
                end else begin
                    w_tcnt = r_tcnt + TW'(1);
                end
            end

            default: begin
                w_state = ST_HUNT;
            end
        endcase
    end

    frame_payload_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_LEN),
        .AW         (AW)
    ) u_buf (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_idx),
        .wdata (rx_data),
        .raddr (buf_addr),
        .rdata (buf_data)
    );

    assign frame_valid = (r_state == ST_HOLD);
    assign frame_cmd   = r_cmd;
    assign frame_len   = r_len;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good frames are queued on a
// scoreboard when sent and checked when held; error and overrun pulses are
// collected by a monitor and compared against the expected causes.
module tb_uart_frame_parser;

    localparam int TO = 50;

    typedef struct packed {
        logic [7:0]   cmd;
        logic [7:0]   len;
        logic [127:0] pl;
    } frame_t;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic [3:0] buf_addr;
    logic [7:0] buf_data;
    logic       err;
    logic [1:0] err_code;
    logic       overrun;

    frame_t     frameQ[$];
    logic [1:0] errExpQ[$];
    logic [1:0] errSeenQ[$];
    int         ovSeen = 0;
    int         ovExp  = 0;
    int         total  = 0;
    int         bad    = 0;

    uart_frame_parser #(
        .DATA_WIDTH     (8),
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .err         (err),
        .err_code    (err_code),
        .overrun     (overrun)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Collect error and overrun pulses shortly after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (err === 1'b1) errSeenQ.push_back(err_code);
        if (overrun === 1'b1) ovSeen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    // Payload byte i is seed + 0x10*i; a corrupted CHK expects a checksum error
    task automatic sendFrame(input logic [7:0] cmd, input logic [7:0] len,
                             input logic [7:0] seed, input bit badChk);
        frame_t     f;
        logic [7:0] chk;
        logic [7:0] b;
        f.cmd = cmd;
        f.len = len;
        f.pl  = '0;
        chk   = cmd ^ len;
        applyStimulus(8'hA5);
        applyStimulus(cmd);
        applyStimulus(len);
        for (int i = 0; i < int'(len); i++) begin
            b = seed + 8'(i * 16);
            f.pl[i*8 +: 8] = b;
            chk = chk ^ b;
            applyStimulus(b);
        end
        if (badChk) begin
            errExpQ.push_back(2'b01);
            applyStimulus(chk ^ 8'h01);
        end else begin
            frameQ.push_back(f);
            applyStimulus(chk);
        end
    endtask

    // Compare the held frame against the front of the scoreboard
    task automatic checkOutput(input string tag);
        frame_t f;
        check({tag, "_valid"}, 32'(frame_valid), 32'd1);
        if (frameQ.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            f = frameQ[0];
            check({tag, "_cmd"}, 32'(frame_cmd), 32'(f.cmd));
            check({tag, "_len"}, 32'(frame_len), 32'(f.len));
            for (int i = 0; i < int'(f.len); i++) begin
                buf_addr = 4'(i);
                #1;
                check($sformatf("%s_buf%0d", tag, i), 32'(buf_data), 32'(f.pl[i*8 +: 8]));
            end
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check({tag, "_released"}, 32'(frame_valid), 32'd0);
        if (frameQ.size() > 0) void'(frameQ.pop_front());
    endtask

    // Compare observed error causes and overrun count with expectations
    task automatic checkErrs(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_errcount"}, 32'(errSeenQ.size()), 32'(errExpQ.size()));
        while (errSeenQ.size() > 0 && errExpQ.size() > 0) begin
            check({tag, "_errcode"}, 32'(errSeenQ.pop_front()), 32'(errExpQ.pop_front()));
        end
        errSeenQ.delete();
        errExpQ.delete();
        check({tag, "_overruns"}, 32'(ovSeen), 32'(ovExp));
    endtask

    // Directed sequence
    initial begin
        arst_n      = 1'b0;
        rx_done     = 1'b0;
        rx_data     = 8'h00;
        frame_ready = 1'b0;
        buf_addr    = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_errcode", 32'(err_code), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_cmd", 32'(frame_cmd), 32'd0);
        check("rst_len", 32'(frame_len), 32'd0);
        arst_n = 1'b1;

        // Good frame A5 01 02 10 20 33
        sendFrame(8'h01, 8'h02, 8'h10, 1'b0);
        checkOutput("good");
        handshake("good");
        checkErrs("good");

        // Bad checksum A5 01 02 10 20 34
        sendFrame(8'h01, 8'h02, 8'h10, 1'b1);
        check("badchk_novalid", 32'(frame_valid), 32'd0);
        checkErrs("badchk");

        // LEN 17 rejected, then A5 01 00 01 accepted
        applyStimulus(8'hA5);
        applyStimulus(8'h07);
        applyStimulus(8'h11);
        errExpQ.push_back(2'b10);
        check("badlen_novalid", 32'(frame_valid), 32'd0);
        checkErrs("badlen");
        sendFrame(8'h01, 8'h00, 8'h00, 1'b0);
        checkOutput("afterlen");
        handshake("afterlen");

        // Junk then zero-length frame: FF 00 A5 05 00 05
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        sendFrame(8'h05, 8'h00, 8'h00, 1'b0);
        checkOutput("zlen");
        handshake("zlen");
        checkErrs("zlen");

        // Full-size frame at LEN = MAX_LEN
        sendFrame(8'h3C, 8'd16, 8'h01, 1'b0);
        checkOutput("maxlen");
        handshake("maxlen");

        // Timeout: must not fire early, must fire by TO cycles
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        repeat (TO - 5) @(negedge clk);
        check("timeout_early", 32'(errSeenQ.size()), 32'd0);
        repeat (10) @(negedge clk);
        errExpQ.push_back(2'b11);
        checkErrs("timeout");
        sendFrame(8'h42, 8'h03, 8'h07, 1'b0);
        checkOutput("aftertimeout");
        handshake("aftertimeout");

        // Overrun while holding: frame must stay intact
        sendFrame(8'h09, 8'h02, 8'h55, 1'b0);
        applyStimulus(8'hA5);
        ovExp++;
        checkOutput("overrun_held");
        checkErrs("overrun");

        // Byte on the handshake cycle is dropped, not parsed as SYNC
        @(negedge clk);
        frame_ready = 1'b1;
        rx_done     = 1'b1;
        rx_data     = 8'hA5;
        @(negedge clk);
        frame_ready = 1'b0;
        rx_done     = 1'b0;
        rx_data     = 8'h00;
        ovExp++;
        if (frameQ.size() > 0) void'(frameQ.pop_front());
        check("hs_byte_released", 32'(frame_valid), 32'd0);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        check("hs_byte_not_sync", 32'(frame_valid), 32'd0);
        checkErrs("hsbyte");

        // Reset in the middle of a payload
        applyStimulus(8'hA5);
        applyStimulus(8'h01);
        applyStimulus(8'h04);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(frame_valid), 32'd0);
        check("midrst_cmd", 32'(frame_cmd), 32'd0);
        check("midrst_len", 32'(frame_len), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        sendFrame(8'h66, 8'h01, 8'hC3, 1'b0);
        checkOutput("afterrst");

        // Reset while holding drops frame_valid without a clock edge
        @(negedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("holdrst_async", 32'(frame_valid), 32'd0);
        if (frameQ.size() > 0) void'(frameQ.pop_front());
        @(negedge clk);
        arst_n = 1'b1;
        checkErrs("final");
        check("final_sb_empty", 32'(frameQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame parser that sits directly downstream of the UART receiver. It consumes each received byte on the receiver's one-cycle `rx_done` strobe. It delimits frames of the form SYNC, CMD, LEN, payload[LEN], CHK and verifies the XOR checksum. Each good frame is presented to the processor-side loader through a valid/ready handshake with a random-access payload buffer.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: byte width; must match the receiver.
- `MAX_LEN`, default 16: maximum payload bytes per frame (1..255).
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 100000: maximum `clk` cycles allowed between bytes inside a frame.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `rx_done`  in  1  one-cycle byte strobe from the receiver.
- `rx_data`  in  DATA_WIDTH  received byte; valid when `rx_done`=1.
- `frame_valid`  out  1  a verified frame is held.
- `frame_ready`  in  1  consumer accepts the frame.
- `frame_cmd`  out  DATA_WIDTH  CMD byte of the held frame.
- `frame_len`  out  DATA_WIDTH  LEN byte of the held frame.
- `buf_addr`  in  $clog2(MAX_LEN)  payload read index.
- `buf_data`  out  DATA_WIDTH  payload[`buf_addr`]; combinational read.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  cause of the error, valid with `err`: 01 checksum, 10 LEN > MAX_LEN, 11 timeout; otherwise 00.
- `overrun`  out  1  one-cycle pulse: byte dropped while a frame was held.

## Operation
- States: HUNT, CMD, LEN, PAYLOAD, CHECK, HOLD. Transitions happen only on `rx_done`, except timeout and handshake.
- HUNT:
  - byte == SYNC_BYTE → CMD.
  - Any other byte is discarded silently, with no error.
- CMD: store the byte into `frame_cmd`, set running checksum = byte, → LEN.
- LEN:
  - byte > MAX_LEN → `err` with code 10, → HUNT.
  - Otherwise store it in `frame_len`, fold it into the checksum, clear the payload index.
  - Byte 0 → CHECK; otherwise → PAYLOAD.
- PAYLOAD:
  - Write the byte to buffer[index], fold it into the checksum, increment the index.
  - When index reaches LEN-1 (last payload byte written) → CHECK.
- CHECK:
  - byte == checksum → HOLD, `frame_valid`=1.
  - Otherwise `err` with code 01, → HUNT.
- HOLD:
  - `frame_valid`=1; `frame_cmd`, `frame_len` and the buffer are frozen.
  - `frame_valid && frame_ready` → HUNT.
  - Any `rx_done` in HOLD drops the byte and pulses `overrun`. This includes the handshake cycle itself: the handshake wins and the byte is not parsed as SYNC.
- Checksum: 8-bit XOR of CMD, LEN and every payload byte. SYNC and CHK are excluded.
- Timeout:
  - Counter cleared on every `rx_done` and while in HUNT or HOLD; increments every cycle in CMD, LEN, PAYLOAD and CHECK.
  - On reaching TIMEOUT_CYCLES-1 → `err` with code 11, → HUNT. The partial frame is discarded.
- The buffer is not cleared between frames. Entries at index ≥ LEN are stale, and their value is don't-care to the consumer.

## Timing
- Reset values:
  - state HUNT.
  - `frame_valid`, `err`, `overrun` = 0.
  - `err_code`, `frame_cmd`, `frame_len` = 0.
  - Checksum, index and timeout counter = 0.
  - Buffer contents are undefined.
- Reset asserted mid-frame or in HOLD: immediate return to HUNT, `frame_valid` drops asynchronously.
- `frame_valid` rises on the cycle after the `rx_done` carrying a matching CHK. `frame_cmd` and `frame_len` are valid in that same cycle.
- `frame_valid` falls on the cycle after the handshake. A SYNC byte can be parsed from the next cycle onward.
- `err` and `overrun` are registered and one cycle wide, asserted the cycle after the causing event. Timeout and a byte arrival cannot coincide, because `rx_done` clears the counter first.
- `buf_data` follows `buf_addr` combinationally; it has no read latency.
- `frame_ready` while `frame_valid`=0 is ignored.

## Structure
- Shared package `uart_pkg`:
  - parser state enum `frame_state_t`;
  - error code enum `frame_err_t` (NONE, CHKSUM, LEN, TIMEOUT);
  - default `SYNC_BYTE` constant.
- One sub-module, `frame_payload_buf`: MAX_LEN × DATA_WIDTH register file with synchronous write (we, waddr, wdata) and asynchronous read.
- The parser FSM, checksum, index and timeout counter live in `uart_frame_parser`.

## Test plan
- Good frame:
  - Stimulus: bytes A5 01 02 10 20 33.
  - Response: `frame_valid`=1 one cycle after the 33; `frame_cmd`=01, `frame_len`=02; `buf_addr` 0/1 → 10/20.
  - Holding `frame_ready`=1 for one cycle drops `frame_valid` on the next cycle.
- Bad checksum and length:
  - Bytes A5 01 02 10 20 34 → `err` with code 01, no `frame_valid`.
  - Bytes A5 07 11 (LEN=17 > 16) → `err` with code 10 after the 11; the following frame A5 01 00 01 is accepted.
- Zero-length frame plus junk:
  - Stimulus: bytes FF 00 A5 05 00 05.
  - Response: FF and 00 ignored silently; `frame_valid` with `frame_cmd`=05, `frame_len`=00.
- Timeout:
  - Stimulus: bytes A5 01, then idle TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES=50 in the bench).
  - Response: `err` with code 11; the next full frame parses correctly.
- Overrun and reset:
  - With a frame held and `frame_ready`=0, send A5 → `overrun` pulse; the held frame is unchanged.
  - Assert `arst_n`=0 during PAYLOAD → all outputs at reset values and state HUNT after release.
